// File: rtl/instruction_fetch.sv
// instruction_fetch: program counter and fetch sequencer in front of a
// synchronous instruction memory with one-cycle registered read latency.
//
// Build option: define IFETCH_HALT_DETECT_EN to stop fetching when a valid
// word carrying HALT_OPCODE in its top six bits is loaded. When the option is
// left undefined, fetch free-runs and halted stays 0.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   stall          consumer not accepting; outputs and fetch position hold
//   redirect       load redirect_addr as the new fetch address, flush in-flight
//   redirect_addr  redirect target
//   mem_q          registered read data from instruction memory
//   read_addr      address to instruction memory (combinational)
//   instr          fetched instruction word (registered)
//   instr_pc       address of instr (registered)
//   instr_valid    instr / instr_pc valid (registered)
//   halted         halt opcode reached, fetching stopped (registered)
module instruction_fetch #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [5:0]  HALT_OPCODE = 6'b011010
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    output logic                  halted
);

    localparam int unsigned OPC_W = 6;

`ifdef IFETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef enum logic {RUN, HALTED} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_nx;
    logic [ADDR_WIDTH-1:0] resp_pc, resp_pc_nx;
    logic                  resp_valid, resp_valid_nx;
    logic [DATA_WIDTH-1:0] instr_nx;
    logic [ADDR_WIDTH-1:0] instr_pc_nx;
    logic                  instr_valid_nx;
    logic                  halted_nx;
    logic                  halt_hit_c;

    // Under stall the memory re-reads the word already on mem_q so it stays put.
    assign read_addr = stall ? resp_pc : fetch_pc;

    // Valid word on mem_q carries the halt opcode (constant 0 when disabled).
    assign halt_hit_c = HALT_EN && resp_valid &&
                        (mem_q[DATA_WIDTH-1 -: OPC_W] == HALT_OPCODE);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            fetch_pc    <= '0;
            resp_pc     <= '0;
            resp_valid  <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_nx;
            fetch_pc    <= fetch_pc_nx;
            resp_pc     <= resp_pc_nx;
            resp_valid  <= resp_valid_nx;
            instr       <= instr_nx;
            instr_pc    <= instr_pc_nx;
            instr_valid <= instr_valid_nx;
            halted      <= halted_nx;
        end
    end

    // Next state: redirect beats stall beats normal advance.
    always_comb begin
        state_nx       = state;
        fetch_pc_nx    = fetch_pc;
        resp_pc_nx     = resp_pc;
        resp_valid_nx  = resp_valid;
        instr_nx       = instr;
        instr_pc_nx    = instr_pc;
        instr_valid_nx = instr_valid;
        halted_nx      = halted;

        if (redirect) begin
            fetch_pc_nx    = redirect_addr;
            resp_valid_nx  = 1'b0;
            instr_valid_nx = 1'b0;
            halted_nx      = 1'b0;
            state_nx       = RUN;
        end else if (!stall) begin
            case (state)
                RUN: begin
                    instr_nx       = mem_q;
                    instr_pc_nx    = resp_pc;
                    instr_valid_nx = resp_valid;
                    if (halt_hit_c) begin
                        // Halt word is presented; its prefetched successor is dropped.
                        state_nx      = HALTED;
                        halted_nx     = 1'b1;
                        resp_valid_nx = 1'b0;
                    end else begin
                        resp_pc_nx    = fetch_pc;
                        resp_valid_nx = 1'b1;
                        fetch_pc_nx   = ADDR_WIDTH'(fetch_pc + 1'b1);
                    end
                end
                HALTED: begin
                    instr_valid_nx = 1'b0;
                end
                default: begin
                    state_nx = RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed bench for instruction_fetch with a
// synchronous instruction memory model (word[i] = i, word 14 = halt opcode).
module tb_instruction_fetch;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 10;
    localparam logic [31:0] HALT_WORD  = 32'h6800_0000;

`ifdef IFETCH_HALT_DETECT_EN
    localparam bit HALT_EXP = 1'b1;
`else
    localparam bit HALT_EXP = 1'b0;
`endif

    logic                  clk;
    logic                  rst_n;
    logic                  stall;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_addr;
    logic [DATA_WIDTH-1:0] mem_q;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_valid;
    logic                  halted;

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .HALT_OPCODE(6'b011010)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .mem_q        (mem_q),
        .read_addr    (read_addr),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: one-cycle registered read.
    always @(posedge clk) mem_q <= mem[read_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Outputs are sampled at the falling edge, after the preceding rising edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_word(input int pc, input logic [31:0] data, input bit h);
        check("valid", 32'(instr_valid), 32'd1);
        check("instr_pc", 32'(instr_pc), 32'(pc));
        check("instr", instr, data);
        check("halted", 32'(halted), 32'(h));
    endtask

    task automatic expect_bubble(input bit h);
        check("bubble_valid", 32'(instr_valid), 32'd0);
        check("bubble_halted", 32'(halted), 32'(h));
    endtask

    task automatic do_redirect(input int addr);
        redirect      = 1'b1;
        redirect_addr = ADDR_WIDTH'(addr);
        tick();
        redirect      = 1'b0;
        expect_bubble(1'b0);
        tick();
        expect_bubble(1'b0);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem[i] = 32'(i);
        mem[14]       = HALT_WORD;
        mem_q         = '0;
        rst_n         = 1'b0;
        stall         = 1'b0;
        redirect      = 1'b0;
        redirect_addr = '0;

        // Reset values.
        repeat (2) tick();
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_pc", 32'(instr_pc), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_read_addr", 32'(read_addr), 32'd0);

        // First valid word after the second rising edge, then one per cycle.
        rst_n = 1'b1;
        tick();
        expect_bubble(1'b0);
        for (int pc = 0; pc <= 5; pc++) begin
            tick();
            expect_word(pc, 32'(pc), 1'b0);
        end

        // Three stall cycles while instr_pc = 5: word 5 shown four cycles total.
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_word(5, 32'd5, 1'b0);
        end
        stall = 1'b0;
        for (int pc = 6; pc <= 10; pc++) begin
            tick();
            expect_word(pc, 32'(pc), 1'b0);
        end

        // Redirect at instr_pc = 10: two bubbles, words 11/12 never valid.
        do_redirect(32'h200);
        for (int pc = 32'h200; pc <= 32'h202; pc++) begin
            tick();
            expect_word(pc, 32'(pc), 1'b0);
        end

        // Address wrap at the top of the space.
        do_redirect(32'h3FE);
        tick(); expect_word(32'h3FE, 32'h3FE, 1'b0);
        tick(); expect_word(32'h3FF, 32'h3FF, 1'b0);
        tick(); expect_word(0, 32'd0, 1'b0);
        tick(); expect_word(1, 32'd1, 1'b0);

        // Halt word at 14; a stall in that cycle keeps it presented.
        do_redirect(12);
        tick(); expect_word(12, 32'd12, 1'b0);
        tick(); expect_word(13, 32'd13, 1'b0);
        tick(); expect_word(14, HALT_WORD, HALT_EXP);
        stall = 1'b1;
        tick(); expect_word(14, HALT_WORD, HALT_EXP);
        stall = 1'b0;
`ifdef IFETCH_HALT_DETECT_EN
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_bubble(1'b1);
        end
`else
        for (int pc = 15; pc <= 17; pc++) begin
            tick();
            expect_word(pc, 32'(pc), 1'b0);
        end
`endif

        // Redirect to 0 clears halted and restarts.
        do_redirect(0);
        for (int pc = 0; pc <= 7; pc++) begin
            tick();
            expect_word(pc, 32'(pc), 1'b0);
        end

        // Asynchronous reset in the middle of a stall at instr_pc = 7.
        stall = 1'b1;
        tick();
        expect_word(7, 32'd7, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(instr_valid), 32'd0);
        check("async_halted", 32'(halted), 32'd0);
        check("async_pc", 32'(instr_pc), 32'd0);
        check("async_instr", instr, 32'd0);
        tick();
        stall = 1'b0;
        check("async_read_addr", 32'(read_addr), 32'd0);
        rst_n = 1'b1;
        tick();
        expect_bubble(1'b0);
        tick(); expect_word(0, 32'd0, 1'b0);
        tick(); expect_word(1, 32'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
